// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, flag bit positions, field constants.
// Widths are passed in so one package serves every exponent/fraction format.
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_t;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int FP_MAX_W = 64;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [FP_MAX_W-1:0] qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [FP_MAX_W-1:0] inf(input logic sign, input int exp_w, input int man_w);
        return (64'(sign) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
    endfunction

    // Subnormals (exp==0, frac!=0) deliberately classify as zero: the units flush them.
    function automatic fp_class_t classify(input logic [31:0] exp, input logic [63:0] frac,
                                           input int exp_w);
        logic [31:0] ones;
        ones = (32'd1 << exp_w) - 32'd1;
        if (exp == 32'd0)
            return FP_ZERO;
        else if (exp == ones)
            return (frac == 64'd0) ? FP_INF : FP_NAN;
        else
            return FP_NORMAL;
    endfunction

endpackage

// File: rtl/fp_restoring_divider.sv
// Unsigned restoring divider: N quotient bits of dividend/divisor, MSB is the integer bit.
// Latency: N cycles after start; done is high during the cycle whose edge writes the last bit.
// Backpressure: none; start restarts unconditionally, caller must keep dividend < 2*divisor.
module fp_restoring_divider #(
    parameter int N = 13
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic         rem_nz
);
    localparam int CW = $clog2(N + 1);

    logic [N:0]    rem_q;
    logic [N-1:0]  dvsr_q;
    logic [CW-1:0] cnt_q;
    logic [N+1:0]  diff;
    logic          ge;
    logic [N:0]    rem_next;

    always_comb begin
        diff     = {1'b0, rem_q} - {2'b00, dvsr_q};
        ge       = ~diff[N+1];
        rem_next = ge ? diff[N:0] : rem_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            quotient <= '0;
        end else if (start) begin
            rem_q    <= {1'b0, dividend};
            dvsr_q   <= divisor;
            cnt_q    <= CW'(N);
            quotient <= '0;
        end else if (cnt_q != '0) begin
            // Partial remainder stays below divisor, so the shift never drops a set bit.
            rem_q    <= {rem_next[N-1:0], 1'b0};
            quotient <= {quotient[N-2:0], ge};
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    assign done   = (cnt_q == CW'(1));
    assign rem_nz = |rem_q;

endmodule

// File: rtl/fp_div_iter.sv
// Iterative fp divider with RNE rounding, special values, flush-to-zero and exception flags.
// Latency: fixed MAN_W+5 cycles from accept to the one-cycle data_valid_out pulse.
// Backpressure: ready_out low while busy; data_valid_in is ignored until back in IDLE.
module fp_div_iter
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       data_valid_in,
    output logic                       ready_out,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       data_valid_out,
    output logic [4:0]                 flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int N    = MAN_W + 3;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = bias(EXP_W);

    localparam logic [W-1:0]         QNAN   = W'(qnan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_NORM   = 2'd2;
    localparam logic [1:0] S_ROUND  = 2'd3;

    logic [1:0]             state;
    logic                   sign_q, spc_q, guard_q, sticky_q;
    logic [W-1:0]           spc_res_q;
    logic [4:0]             spc_flags_q;
    logic signed [EW-1:0]   e_q;
    logic [MAN_W-1:0]       frac_q;

    logic                   sign_c, spc_c;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    fp_class_t              ca, cb;
    logic [W-1:0]           spc_res_c;
    logic [4:0]             spc_flags_c;
    logic signed [EW-1:0]   e_c;

    logic                   accept, div_done, rem_nz;
    logic [N-1:0]           quotient;

    assign ready_out = (state == S_IDLE);
    assign accept    = ready_out & data_valid_in;
    assign sign_c    = a[W-1] ^ b[W-1];
    assign ea        = a[W-2:MAN_W];
    assign eb        = b[W-2:MAN_W];
    assign fa        = a[MAN_W-1:0];
    assign fb        = b[MAN_W-1:0];
    assign e_c       = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EW'(BIAS);

    // Special operands are resolved up front; the datapath still runs so latency is fixed.
    always_comb begin
        ca          = classify(32'(ea), 64'(fa), EXP_W);
        cb          = classify(32'(eb), 64'(fb), EXP_W);
        spc_c       = 1'b1;
        spc_res_c   = QNAN;
        spc_flags_c = '0;
        if (ca == FP_NAN || cb == FP_NAN) begin
            spc_res_c = QNAN;
        end else if ((ca == FP_ZERO && cb == FP_ZERO) || (ca == FP_INF && cb == FP_INF)) begin
            spc_flags_c[FLAG_NV] = 1'b1;
        end else if (ca == FP_INF) begin
            spc_res_c = W'(inf(sign_c, EXP_W, MAN_W));
        end else if (cb == FP_ZERO) begin
            spc_res_c            = W'(inf(sign_c, EXP_W, MAN_W));
            spc_flags_c[FLAG_DZ] = 1'b1;
        end else if (cb == FP_INF || ca == FP_ZERO) begin
            spc_res_c = {sign_c, {(W-1){1'b0}}};
        end else begin
            spc_c = 1'b0;
        end
    end

    fp_restoring_divider #(.N(N)) u_div (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (accept),
        .dividend (N'({1'b1, fa})),
        .divisor  (N'({1'b1, fb})),
        .done     (div_done),
        .quotient (quotient),
        .rem_nz   (rem_nz)
    );

    logic                 round_up;
    logic [MAN_W:0]       frac_inc;
    logic signed [EW-1:0] e_r;
    logic [W-1:0]         res_c;
    logic [4:0]           flags_c;

    // A carry out of the fraction leaves all-zero low bits, i.e. mantissa 1.0 at E+1.
    always_comb begin
        round_up         = guard_q & (sticky_q | frac_q[0]);
        frac_inc         = {1'b0, frac_q} + (MAN_W+1)'(round_up);
        e_r              = e_q + EW'(frac_inc[MAN_W]);
        res_c            = {sign_q, e_r[EXP_W-1:0], frac_inc[MAN_W-1:0]};
        flags_c          = '0;
        flags_c[FLAG_NX] = guard_q | sticky_q;
        if (spc_q) begin
            res_c   = spc_res_q;
            flags_c = spc_flags_q;
        end else if (e_r >= E_MAX) begin
            res_c            = W'(inf(sign_q, EXP_W, MAN_W));
            flags_c[FLAG_OF] = 1'b1;
            flags_c[FLAG_NX] = 1'b1;
        end else if (e_r <= E_ZERO) begin
            res_c            = {sign_q, {(W-1){1'b0}}};
            flags_c[FLAG_UF] = 1'b1;
            flags_c[FLAG_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state          <= S_IDLE;
            result         <= '0;
            flags          <= '0;
            data_valid_out <= 1'b0;
            sign_q         <= 1'b0;
            spc_q          <= 1'b0;
            spc_res_q      <= '0;
            spc_flags_q    <= '0;
            e_q            <= '0;
            frac_q         <= '0;
            guard_q        <= 1'b0;
            sticky_q       <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            case (state)
                S_IDLE: if (data_valid_in) begin
                    sign_q      <= sign_c;
                    spc_q       <= spc_c;
                    spc_res_q   <= spc_res_c;
                    spc_flags_q <= spc_flags_c;
                    e_q         <= e_c;
                    state       <= S_DIVIDE;
                end
                S_DIVIDE: if (div_done) state <= S_NORM;
                S_NORM: begin
                    if (quotient[N-1]) begin
                        frac_q   <= quotient[N-2:2];
                        guard_q  <= quotient[1];
                        sticky_q <= rem_nz | quotient[0];
                    end else begin
                        frac_q   <= quotient[N-3:1];
                        guard_q  <= quotient[0];
                        sticky_q <= rem_nz;
                        e_q      <= e_q - EW'(1);
                    end
                    state <= S_ROUND;
                end
                default: begin
                    result         <= res_c;
                    flags          <= flags_c;
                    data_valid_out <= 1'b1;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: binary16 instance plus a binary32 instance for rounding.
module tb_fp_div_iter;
    logic        clk_in = 1'b0;
    logic        rst;
    logic [15:0] a, b, result;
    logic        dvi, ready_out, dvo;
    logic [4:0]  flags;
    logic [31:0] a32, b32, result32;
    logic        dvi32, ready32, dvo32;
    logic [4:0]  flags32;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_in = ~clk_in;

    fp_div_iter dut (
        .clk_in(clk_in), .rst(rst), .a(a), .b(b), .data_valid_in(dvi),
        .ready_out(ready_out), .result(result), .data_valid_out(dvo), .flags(flags)
    );

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk_in(clk_in), .rst(rst), .a(a32), .b(b32), .data_valid_in(dvi32),
        .ready_out(ready32), .result(result32), .data_valid_out(dvo32), .flags(flags32)
    );

    task automatic run16(input logic [15:0] av, input logic [15:0] bv,
                         output logic [15:0] r, output logic [4:0] f, output int lat);
        @(negedge clk_in);
        a = av; b = bv; dvi = 1'b1;
        @(posedge clk_in);
        #1 dvi = 1'b0;
        lat = -1; r = 'x; f = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_in); #1;
            if (dvo) begin lat = i; r = result; f = flags; break; end
        end
    endtask

    task automatic run32(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic [4:0] f, output int lat);
        @(negedge clk_in);
        a32 = av; b32 = bv; dvi32 = 1'b1;
        @(posedge clk_in);
        #1 dvi32 = 1'b0;
        lat = -1; r = 'x; f = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_in); #1;
            if (dvo32) begin lat = i; r = result32; f = flags32; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
        checks++; if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags); end
        checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dvo); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_out); end
        checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL reset_ready32 got %b want 1", ready32); end
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] r; logic [4:0] f; int lat;
        run16(16'h4200, 16'h3E00, r, f, lat);
        checks++; if (r !== 16'h4000) begin errors++; $display("FAIL div_3_1p5 got %h want 4000", r); end
        checks++; if (f !== 5'b0) begin errors++; $display("FAIL div_3_1p5_flags got %b want 00000", f); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL latency16 got %0d want 15", lat); end
        run16(16'hC600, 16'h4000, r, f, lat);
        checks++; if (r !== 16'hC200) begin errors++; $display("FAIL div_m6_2 got %h want c200", r); end
        checks++; if (f !== 5'b0) begin errors++; $display("FAIL div_m6_2_flags got %b want 00000", f); end
    endtask

    task automatic test_round;
        logic [15:0] r; logic [31:0] r32; logic [4:0] f; int lat;
        run16(16'h3C00, 16'h4200, r, f, lat);
        checks++; if (r !== 16'h3555) begin errors++; $display("FAIL third16 got %h want 3555", r); end
        checks++; if (f !== 5'b00001) begin errors++; $display("FAIL third16_flags got %b want 00001", f); end
        run32(32'h3F800000, 32'h40400000, r32, f, lat);
        checks++; if (r32 !== 32'h3EAAAAAB) begin errors++; $display("FAIL third32 got %h want 3eaaaaab", r32); end
        checks++; if (f !== 5'b00001) begin errors++; $display("FAIL third32_flags got %b want 00001", f); end
        checks++; if (lat !== 28) begin errors++; $display("FAIL latency32 got %0d want 28", lat); end
    endtask

    task automatic test_specials;
        logic [15:0] ta [5] = '{16'h3C00, 16'h0000, 16'h7C00, 16'h7E01, 16'h3C00};
        logic [15:0] tb [5] = '{16'h0000, 16'h0000, 16'h7C00, 16'h3C00, 16'hFC00};
        logic [15:0] tr [5] = '{16'h7C00, 16'h7E00, 16'h7E00, 16'h7E00, 16'h8000};
        logic [4:0]  tf [5] = '{5'b01000, 5'b10000, 5'b10000, 5'b00000, 5'b00000};
        logic [15:0] r; logic [4:0] f; int lat;
        for (int i = 0; i < 5; i++) begin
            run16(ta[i], tb[i], r, f, lat);
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL special%0d got %h want %h", i, r, tr[i]); end
            checks++; if (f !== tf[i]) begin errors++; $display("FAIL special%0d_flags got %b want %b", i, f, tf[i]); end
        end
    endtask

    task automatic test_range;
        logic [15:0] ta [3] = '{16'h7BFF, 16'h0400, 16'h0001};
        logic [15:0] tb [3] = '{16'h1400, 16'h4000, 16'h3C00};
        logic [15:0] tr [3] = '{16'h7C00, 16'h0000, 16'h0000};
        logic [4:0]  tf [3] = '{5'b00101, 5'b00011, 5'b00000};
        logic [15:0] r; logic [4:0] f; int lat;
        for (int i = 0; i < 3; i++) begin
            run16(ta[i], tb[i], r, f, lat);
            checks++; if (r !== tr[i]) begin errors++; $display("FAIL range%0d got %h want %h", i, r, tr[i]); end
            checks++; if (f !== tf[i]) begin errors++; $display("FAIL range%0d_flags got %b want %b", i, f, tf[i]); end
        end
    endtask

    task automatic test_busy_ignore;
        logic [15:0] r; logic [4:0] f; int lat; int extra;
        logic busy_ready;
        @(negedge clk_in);
        a = 16'h4200; b = 16'h3E00; dvi = 1'b1;
        @(posedge clk_in);
        #1 dvi = 1'b0;
        lat = -1; r = 'x; f = 'x; busy_ready = 1'bx;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_in); #1;
            if (i == 3) begin
                busy_ready = ready_out;
                a = 16'h3C00; b = 16'h0000; dvi = 1'b1;
            end
            if (i == 4) dvi = 1'b0;
            if (dvo) begin lat = i; r = result; f = flags; break; end
        end
        checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", busy_ready); end
        checks++; if (r !== 16'h4000) begin errors++; $display("FAIL busy_result got %h want 4000", r); end
        checks++; if (f !== 5'b0) begin errors++; $display("FAIL busy_flags got %b want 00000", f); end
        checks++; if (lat !== 15) begin errors++; $display("FAIL busy_latency got %0d want 15", lat); end
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_in); #1;
            if (dvo) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_extra_pulses got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r; logic [4:0] f; int lat; logic rdy;
        run16(16'h4200, 16'h3E00, r, f, lat);
        checks++; if (r !== 16'h4000) begin errors++; $display("FAIL b2b_first got %h want 4000", r); end
        rdy = ready_out;
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_valid got %b want 1", rdy); end
        a = 16'hC600; b = 16'h4000; dvi = 1'b1;
        @(posedge clk_in);
        #1 dvi = 1'b0;
        checks++; if (dvo !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got %b want 0", dvo); end
        lat = -1; r = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk_in); #1;
            if (dvo) begin lat = i; r = result; break; end
        end
        checks++; if (lat !== 15) begin errors++; $display("FAIL b2b_latency got %0d want 15", lat); end
        checks++; if (r !== 16'hC200) begin errors++; $display("FAIL b2b_second got %h want c200", r); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] r; logic [4:0] f; int lat; int pulses;
        run16(16'h3C00, 16'h0000, r, f, lat);
        checks++; if (f !== 5'b01000) begin errors++; $display("FAIL pre_reset_flags got %b want 01000", f); end
        @(negedge clk_in);
        a = 16'h4200; b = 16'h3E00; dvi = 1'b1;
        @(posedge clk_in);
        #1 dvi = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL midrst_result got %h want 0000", result); end
        checks++; if (flags !== 5'b0) begin errors++; $display("FAIL midrst_flags got %b want 00000", flags); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready_out); end
        @(negedge clk_in);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_in); #1;
            if (dvo) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
    endtask

    initial begin
        rst = 1'b1; dvi = 1'b0; a = '0; b = '0;
        dvi32 = 1'b0; a32 = '0; b32 = '0;
        test_reset;
        test_basic;
        test_round;
        test_specials;
        test_range;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
